// File: rtl/lca_sched_pkg.sv
// lca_sched_pkg: shared definitions for the two-requester adder scheduler.
//   - op encodings (OP_ADD, OP_SUB, OP_ADDC, OP_RSVD)
//   - scheduler state enum
//   - is_two_pass(): whether an op needs a second pass through the adder
package lca_sched_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDC = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // SUB adds the +1 of the two's complement in pass 2; ADDC adds cin there.
    // The reserved encoding behaves exactly like ADD.
    function automatic logic is_two_pass(input logic [1:0] op);
        case (op)
            OP_SUB:  return 1'b1;
            OP_ADDC: return 1'b1;
            OP_RSVD: return 1'b0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lca.sv
// LCA: N-bit lookahead carry adder, carry-in fixed at 0.
//   a, b  : operands (N bits, N a multiple of 4)
//   sum   : a + b mod 2^N
//   cout  : carry out of the top bit
// Built from 4-bit lookahead groups; group carries chain between groups.
module LCA #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int G = N / 4;

    logic [N-1:0] p;
    logic [N-1:0] g;

    assign p = a ^ b;
    assign g = a & b;

    genvar gi;
    generate
        for (gi = 0; gi < G; gi++) begin : g_grp
            localparam int B = gi * 4;
            logic       ci;
            logic       co;
            logic [3:0] cb;

            if (gi == 0) begin : g_first
                assign ci = 1'b0;
            end else begin : g_next
                assign ci = g_grp[gi-1].co;
            end

            assign cb[0] = ci;
            assign cb[1] = g[B]   | (p[B] & ci);
            assign cb[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
            assign cb[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                         | (p[B+2] & p[B+1] & p[B] & ci);
            assign co    = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B])
                         | (p[B+3] & p[B+2] & p[B+1] & p[B] & ci);

            assign sum[B+3:B] = p[B+3:B] ^ cb;
        end
    endgenerate

    assign cout = g_grp[G-1].co;

endmodule

// File: rtl/lca_sched_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   valid    : request present per requester
//   accept   : the current grant was taken this cycle (moves the pointer)
//   grant    : one-hot grant, combinational from valid and the pointer
// The pointer remembers the last served requester (reset 1, so requester 0
// wins the first contested cycle) and only moves on an accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_reg;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/lca_sched.sv
// lca_sched: schedules ADD / SUB / ADDC from two requesters through one
// shared lookahead carry adder.
//   clk, rst              : clock, asynchronous active-high reset
//   reqX_valid/ready      : request handshake (X = 0, 1)
//   reqX_op/a/b/cin       : op code, operands, carry-in (ADDC only)
//   rsp_valid/ready       : registered response handshake
//   rsp_id/sum/cout       : requester index, result, carry-out
//   busy                  : not in IDLE
// The adder only ever sees registered operands, so there is no combinational
// path from request ports to response outputs.
module lca_sched
    import lca_sched_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         busy
);

    state_t       state_reg;
    logic [1:0]   op_reg;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         cin_reg;
    logic         id_reg;
    logic [N-1:0] t_reg;
    logic         c1_reg;
    logic         rsp_valid_reg;
    logic         rsp_id_reg;
    logic [N-1:0] rsp_sum_reg;
    logic         rsp_cout_reg;
    logic         busy_reg;

    logic [1:0]   grant;
    logic [1:0]   ready;
    logic         accept;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N-1:0] add_sum;
    logic         add_cout;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    // Grant only reaches the ready outputs in IDLE and never while reset is held.
    assign ready      = grant & {2{(state_reg == S_IDLE) && !rst}};
    assign accept     = |ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    // Pass 1: a + b (or a + ~b for SUB). Pass 2: t + 1 (SUB) or t + cin (ADDC).
    always_comb begin
        add_a = a_reg;
        add_b = b_reg;
        if (state_reg == S_PASS2) begin
            add_a = t_reg;
            add_b = {{(N-1){1'b0}}, (op_reg == OP_SUB) ? 1'b1 : cin_reg};
        end else if (op_reg == OP_SUB) begin
            add_b = ~b_reg;
        end
    end

    LCA #(.N(N)) u_lca (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= OP_ADD;
            a_reg         <= '0;
            b_reg         <= '0;
            cin_reg       <= 1'b0;
            id_reg        <= 1'b0;
            t_reg         <= '0;
            c1_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg    <= ready[1] ? req1_op  : req0_op;
                        a_reg     <= ready[1] ? req1_a   : req0_a;
                        b_reg     <= ready[1] ? req1_b   : req0_b;
                        cin_reg   <= ready[1] ? req1_cin : req0_cin;
                        id_reg    <= ready[1];
                        state_reg <= S_PASS1;
                        busy_reg  <= 1'b1;
                    end
                end
                S_PASS1: begin
                    t_reg  <= add_sum;
                    c1_reg <= add_cout;
                    if (is_two_pass(op_reg)) begin
                        state_reg <= S_PASS2;
                    end else begin
                        state_reg     <= S_DONE;
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= id_reg;
                        rsp_sum_reg   <= add_sum;
                        rsp_cout_reg  <= add_cout;
                    end
                end
                S_PASS2: begin
                    // At most one of the two pass carries can be set, so OR merges them.
                    t_reg         <= add_sum;
                    state_reg     <= S_DONE;
                    rsp_valid_reg <= 1'b1;
                    rsp_id_reg    <= id_reg;
                    rsp_sum_reg   <= add_sum;
                    rsp_cout_reg  <= c1_reg | add_cout;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_reg     <= S_IDLE;
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_lca_sched.sv
// tb_lca_sched: directed + randomized bench for lca_sched with a behavioural
// arithmetic / round-robin reference model.
module tb_lca_sched;
    import lca_sched_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v_t   [2];
    logic [1:0]   op_t  [2];
    logic [N-1:0] a_t   [2];
    logic [N-1:0] b_t   [2];
    logic         cin_t [2];
    logic         ready0, ready1;
    logic         rsp_ready;
    logic         rsp_valid, rsp_id, rsp_cout, busy;
    logic [N-1:0] rsp_sum;

    int  checks = 0;
    int  errors = 0;
    int  tb_last;
    time hs_t = 0;
    time prev_t = 0;

    always #5 clk = ~clk;

    lca_sched #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v_t[0]),
        .req0_ready (ready0),
        .req0_op    (op_t[0]),
        .req0_a     (a_t[0]),
        .req0_b     (b_t[0]),
        .req0_cin   (cin_t[0]),
        .req1_valid (v_t[1]),
        .req1_ready (ready1),
        .req1_op    (op_t[1]),
        .req1_a     (a_t[1]),
        .req1_b     (b_t[1]),
        .req1_cin   (cin_t[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cout, sum} from plain arithmetic on the op definitions.
    function automatic logic [N:0] ref_result(input logic [1:0] op, input logic [N-1:0] a,
                                              input logic [N-1:0] b, input logic cin);
        logic [N:0] r;
        case (op)
            OP_SUB: begin
                r[N-1:0] = a - b;
                r[N]     = (a >= b);
            end
            OP_ADDC: r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            default: r = {1'b0, a} + {1'b0, b};
        endcase
        return r;
    endfunction

    task automatic set_req(input int r, input logic [1:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic cin);
        op_t[r]  = op;
        a_t[r]   = a;
        b_t[r]   = b;
        cin_t[r] = cin;
        v_t[r]   = 1'b1;
    endtask

    task automatic rand_req(input int r, input bit add_only);
        set_req(r, add_only ? OP_ADD : 2'($urandom_range(0, 3)), $urandom, $urandom,
                1'($urandom_range(0, 1)));
    endtask

    // Wait for a handshake, check the grant against the round-robin model,
    // then follow the op through to its response. Returns at the negedge where
    // rsp_valid is first seen (rsp_ready is expected high).
    task automatic serve(input bit keep, input bit add_only, input bit chk_gap);
        int           n, g, lat;
        logic [1:0]   xop;
        logic [N-1:0] xa, xb;
        logic         xcin;
        logic [N:0]   ex;
        n = 0;
        #1;
        while (!(ready0 || ready1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (v_t[0] && v_t[1]) g = (tb_last == 0) ? 1 : 0;
        else                  g = v_t[1] ? 1 : 0;
        check("grant", 64'({ready1, ready0}), (g == 1) ? 64'd2 : 64'd1);
        xop = op_t[g]; xa = a_t[g]; xb = b_t[g]; xcin = cin_t[g];
        ex = ref_result(xop, xa, xb, xcin);
        @(posedge clk);
        prev_t  = hs_t;
        hs_t    = $time;
        tb_last = g;
        @(negedge clk);
        if (keep) rand_req(g, add_only);
        else      v_t[g] = 1'b0;
        check("pass1_rsp_valid", 64'(rsp_valid), 64'd0);
        check("pass1_busy", 64'(busy), 64'd1);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), (xop == OP_SUB || xop == OP_ADDC) ? 64'd3 : 64'd2);
        check("rsp_sum", 64'(rsp_sum), 64'(ex[N-1:0]));
        check("rsp_cout", 64'(rsp_cout), 64'(ex[N]));
        check("rsp_id", 64'(rsp_id), 64'(g));
        if (chk_gap) check("accept_gap", 64'((hs_t - prev_t) / 10), 64'd3);
        $display("txn id=%0d op=%0d a=%h b=%h cin=%0d sum=%h cout=%0d lat=%0d",
                 g, xop, xa, xb, xcin, rsp_sum, rsp_cout, lat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        check({tag, "_rsp_sum"}, 64'(rsp_sum), 64'd0);
        check({tag, "_rsp_cout"}, 64'(rsp_cout), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_readies"}, 64'({ready1, ready0}), 64'd0);
    endtask

    initial begin
        logic [N-1:0] held_sum;
        logic [N:0]   ex;
        int           n;

        for (int r = 0; r < 2; r++) begin
            v_t[r] = 1'b1; op_t[r] = OP_ADD; a_t[r] = '0; b_t[r] = '0; cin_t[r] = 1'b0;
        end
        rsp_ready = 1'b1;
        tb_last   = 1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        v_t[0] = 1'b0;
        v_t[1] = 1'b0;
        rst    = 1'b0;

        // Directed ops
        set_req(0, OP_ADD, 32'h7, 32'h9, 1'b0);
        serve(0, 0, 0);
        check("add_sum_const", 64'(rsp_sum), 64'h10);
        @(negedge clk);
        check("add_back_idle", 64'(busy), 64'd0);
        set_req(1, OP_SUB, 32'd5, 32'd3, 1'b0);
        serve(0, 0, 0);
        set_req(1, OP_SUB, 32'd3, 32'd5, 1'b0);
        serve(0, 0, 0);
        check("sub_neg_const", 64'(rsp_sum), 64'hFFFFFFFE);
        set_req(0, OP_ADDC, 32'hFFFFFFFF, 32'h0, 1'b1);
        serve(0, 0, 0);
        set_req(0, OP_ADDC, 32'hFFFFFFFF, 32'h0, 1'b0);
        serve(0, 0, 0);
        set_req(1, OP_RSVD, 32'd1, 32'd2, 1'b1);
        serve(0, 0, 0);

        // Reset during PASS2 of a SUB
        @(negedge clk);
        set_req(1, OP_SUB, 32'd100, 32'd1, 1'b0);
        #1;
        check("pre_rst_ready1", 64'(ready1), 64'd1);
        @(posedge clk);
        @(negedge clk);
        v_t[1] = 1'b0;
        @(negedge clk);
        check("pass2_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        rand_req(0, 1);
        rand_req(1, 1);
        #1;
        check_all_zero("midop_rst");
        @(negedge clk);
        rst     = 1'b0;
        tb_last = 1;

        // Both requesters continuously valid: 0,1,0,1 at one accept per 3 cycles
        serve(1, 1, 0);
        for (int i = 0; i < 3; i++) serve(1, 1, 1);
        // Requester 1 drops out; requester 0 keeps its full rate
        v_t[1] = 1'b0;
        serve(1, 1, 1);
        serve(1, 1, 1);

        // Backpressure in DONE with a pending request
        v_t[0] = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        rand_req(0, 0);
        rand_req(1, 0);
        tb_last = 0;
        #1;
        check("bp_grant", 64'({ready1, ready0}), 64'd2);
        ex = ref_result(op_t[1], a_t[1], b_t[1], cin_t[1]);
        @(posedge clk);
        tb_last = 1;
        @(negedge clk);
        v_t[1] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_sum", 64'(rsp_sum), 64'(ex[N-1:0]));
        held_sum = rsp_sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_sum", 64'(rsp_sum), 64'(held_sum));
            check("bp_hold_cout", 64'(rsp_cout), 64'(ex[N]));
            check("bp_hold_readies", 64'({ready1, ready0}), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_busy", 64'(busy), 64'd0);
        check("bp_release_ready0", 64'(ready0), 64'd1);
        serve(0, 0, 0);

        // Randomized mix of requesters and ops
        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v_t[r] && $urandom_range(0, 1) == 1) rand_req(r, 0);
            end
            if (!v_t[0] && !v_t[1]) rand_req(0, 0);
            serve(0, 0, 0);
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
